// File: rtl/seq_num_checker_pkg.sv
// Shared definitions for the MsgSeqNum (tag 34) receive checker.
// Contents: FSM state encoding, result-status encoding, ASCII digit bounds,
// default widths and a digit-classification helper.
package seq_num_checker_pkg;

  localparam int HOST_ADDR_WIDTH = 8;
  localparam int BIN_W_DEF       = 32;
  localparam int MAX_DIGITS_DEF  = 10;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CHECK,
    ST_REPORT
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK,
    STAT_GAP,
    STAT_LOW,
    STAT_ERR
  } status_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/seq_num_checker_if.sv
// Bus bundle between the session manager and the sequence-number checker.
// master: drives start/host/expected and the character stream, receives results.
// slave : the checker side.
interface seq_num_checker_if
  import seq_num_checker_pkg::*;
#(
  parameter int HOST_ADDR = HOST_ADDR_WIDTH,
  parameter int BIN_W     = BIN_W_DEF
);
  logic                 start_i;
  logic [HOST_ADDR-1:0] host_addr_i;
  logic [BIN_W-1:0]     expected_seq_i;
  logic                 char_valid_i;
  logic [7:0]           char_i;
  logic                 char_last_i;

  logic                 busy_o;
  logic                 result_valid_o;
  logic [BIN_W-1:0]     seq_num_o;
  logic                 seq_ok_o;
  logic                 seq_gap_o;
  logic                 seq_low_o;
  logic                 format_err_o;
  logic                 upd_valid_o;
  logic [HOST_ADDR-1:0] upd_host_addr_o;
  logic [BIN_W-1:0]     upd_seq_num_o;

  modport master (
    output start_i, host_addr_i, expected_seq_i, char_valid_i, char_i, char_last_i,
    input  busy_o, result_valid_o, seq_num_o, seq_ok_o, seq_gap_o, seq_low_o,
           format_err_o, upd_valid_o, upd_host_addr_o, upd_seq_num_o
  );

  modport slave (
    input  start_i, host_addr_i, expected_seq_i, char_valid_i, char_i, char_last_i,
    output busy_o, result_valid_o, seq_num_o, seq_ok_o, seq_gap_o, seq_low_o,
           format_err_o, upd_valid_o, upd_host_addr_o, upd_seq_num_o
  );
endinterface

// File: rtl/seq_num_checker_ascii_to_binary.sv
// ascii_to_binary: serial decimal-ASCII to binary accumulator.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   clear        restart accumulation (acc, digit count, err := 0)
//   char_en      consume char_in this cycle
//   char_in      ASCII character
//   acc          accumulated binary value (saturates at all-ones)
//   err          sticky: non-digit seen, too many digits, or overflow
module ascii_to_binary
  import seq_num_checker_pkg::*;
#(
  parameter int BIN_W      = BIN_W_DEF,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             char_en,
  input  logic [7:0]       char_in,
  output logic [BIN_W-1:0] acc,
  output logic             err
);
  localparam int EXT_W = BIN_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIGITS + 1);

  logic [BIN_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  logic [EXT_W-1:0] acc_ext;
  logic [EXT_W-1:0] prod;
  logic [3:0]       digit;
  logic             overflow;

  // For '0'..'9' the low nibble of the ASCII code is the digit value.
  assign digit    = char_in[3:0];
  assign acc_ext  = {4'b0000, acc_reg};
  assign prod     = (acc_ext << 3) + (acc_ext << 1) + {{(EXT_W-4){1'b0}}, digit};
  assign overflow = |prod[EXT_W-1:BIN_W];

  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    err_next = err_reg;
    if (clear) begin
      acc_next = '0;
      cnt_next = '0;
      err_next = 1'b0;
    end else if (char_en) begin
      if (is_digit(char_in)) begin
        // Count saturates at the limit so long fields cannot wrap it.
        if (cnt_reg != CNT_LIMIT) cnt_next = cnt_reg + 1'b1;
        if (cnt_next == CNT_LIMIT) err_next = 1'b1;
        if (overflow) begin
          acc_next = '1;
          err_next = 1'b1;
        end else begin
          acc_next = prod[BIN_W-1:0];
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign acc = acc_reg;
  assign err = err_reg;

endmodule

// File: rtl/seq_num_checker.sv
// seq_num_checker: decodes an incoming ASCII MsgSeqNum, classifies it against
// the expected value for the sending host and requests a counter update when
// it is in order.
// Ports:
//   clk  clock
//   rst  synchronous active-low reset
//   bus  seq_num_checker_if.slave: start/host/expected + character stream in;
//        busy, result pulse + held flags/value, counter-update pulse out.
module seq_num_checker
  import seq_num_checker_pkg::*;
#(
  parameter int HOST_ADDR  = HOST_ADDR_WIDTH,
  parameter int BIN_W      = BIN_W_DEF,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  seq_num_checker_if.slave  bus
);
  state_t state_reg, state_next;

  logic [HOST_ADDR-1:0] host_reg;
  logic [BIN_W-1:0]     expected_reg;

  logic                 result_valid_reg;
  logic [BIN_W-1:0]     seq_num_reg;
  logic                 ok_reg, gap_reg, low_reg, err_reg;
  logic                 upd_valid_reg;
  logic [HOST_ADDR-1:0] upd_host_reg;
  logic [BIN_W-1:0]     upd_seq_reg;

  logic             start_field;
  logic             char_en;
  logic [BIN_W-1:0] acc;
  logic             conv_err;
  status_t          status;

  // CHECK is the only state that ignores start_i.
  assign start_field = bus.start_i && (state_reg != ST_CHECK);
  // A restart in ACCUM drops the character presented in the same cycle.
  assign char_en     = (state_reg == ST_ACCUM) && bus.char_valid_i && !bus.start_i;

  ascii_to_binary #(
    .BIN_W      (BIN_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_a2b (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_field),
    .char_en (char_en),
    .char_in (bus.char_i),
    .acc     (acc),
    .err     (conv_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.start_i) state_next = ST_ACCUM;
      ST_ACCUM: begin
        if (bus.start_i)                              state_next = ST_ACCUM;
        else if (bus.char_valid_i && bus.char_last_i) state_next = ST_CHECK;
      end
      ST_CHECK:  state_next = ST_REPORT;
      ST_REPORT: state_next = bus.start_i ? ST_ACCUM : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Zero is never a valid sequence number; malformed wins over any compare.
  always_comb begin
    status = STAT_OK;
    if (conv_err || (acc == '0))  status = STAT_ERR;
    else if (acc > expected_reg)  status = STAT_GAP;
    else if (acc < expected_reg)  status = STAT_LOW;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      host_reg         <= '0;
      expected_reg     <= '0;
      result_valid_reg <= 1'b0;
      seq_num_reg      <= '0;
      ok_reg           <= 1'b0;
      gap_reg          <= 1'b0;
      low_reg          <= 1'b0;
      err_reg          <= 1'b0;
      upd_valid_reg    <= 1'b0;
      upd_host_reg     <= '0;
      upd_seq_reg      <= '0;
    end else begin
      result_valid_reg <= 1'b0;
      upd_valid_reg    <= 1'b0;
      if (start_field) begin
        host_reg     <= bus.host_addr_i;
        expected_reg <= bus.expected_seq_i;
        seq_num_reg  <= '0;
        ok_reg       <= 1'b0;
        gap_reg      <= 1'b0;
        low_reg      <= 1'b0;
        err_reg      <= 1'b0;
        upd_host_reg <= '0;
        upd_seq_reg  <= '0;
      end else if (state_reg == ST_CHECK) begin
        result_valid_reg <= 1'b1;
        seq_num_reg      <= acc;
        ok_reg           <= (status == STAT_OK);
        gap_reg          <= (status == STAT_GAP);
        low_reg          <= (status == STAT_LOW);
        err_reg          <= (status == STAT_ERR);
        if (status == STAT_OK) begin
          upd_valid_reg <= 1'b1;
          upd_host_reg  <= host_reg;
          upd_seq_reg   <= acc + 1'b1;  // wraps modulo 2^BIN_W
        end
      end
    end
  end

  assign bus.busy_o          = (state_reg != ST_IDLE);
  assign bus.result_valid_o  = result_valid_reg;
  assign bus.seq_num_o       = seq_num_reg;
  assign bus.seq_ok_o        = ok_reg;
  assign bus.seq_gap_o       = gap_reg;
  assign bus.seq_low_o       = low_reg;
  assign bus.format_err_o    = err_reg;
  assign bus.upd_valid_o     = upd_valid_reg;
  assign bus.upd_host_addr_o = upd_host_reg;
  assign bus.upd_seq_num_o   = upd_seq_reg;

endmodule

// File: tb/tb_seq_num_checker.sv
// Self-checking bench for seq_num_checker: expected results are queued when a
// field is driven and compared when the result pulse appears.
module tb_seq_num_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_num_checker_if #(.HOST_ADDR(8), .BIN_W(32)) bus ();

  seq_num_checker #(.HOST_ADDR(8), .BIN_W(32), .MAX_DIGITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] seq;
    bit          chk_seq;
    logic        ok, gap, low, err;
    logic [7:0]  host;
    logic [31:0] upd_seq;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_field(input logic [7:0] host, input logic [31:0] expv);
    bus.start_i        = 1'b1;
    bus.host_addr_i    = host;
    bus.expected_seq_i = expv;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_chars(input string s, input bit mark_last, output int last_cyc);
    last_cyc = cyc;
    for (int i = 0; i < s.len(); i++) begin
      bus.char_valid_i = 1'b1;
      bus.char_i       = s[i];
      bus.char_last_i  = mark_last && (i == s.len() - 1);
      last_cyc         = cyc;
      tick();
    end
    bus.char_valid_i = 1'b0;
    bus.char_last_i  = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [31:0] seq, input bit chk_seq,
                          input logic ok, input logic gap, input logic low, input logic err,
                          input logic [7:0] host, input logic [31:0] upd_seq);
    exp_t e;
    e.name = name; e.seq = seq; e.chk_seq = chk_seq;
    e.ok = ok; e.gap = gap; e.low = low; e.err = err;
    e.host = host; e.upd_seq = upd_seq;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: waits (bounded) for the result pulse and compares
  // it with the oldest queued expectation.
  task automatic await_result(input int last_cyc);
    int   waited = 0;
    bit   found = 0;
    exp_t e;
    while (!found && waited < 12) begin
      @(negedge clk);
      if (bus.result_valid_o === 1'b1) found = 1;
      else waited++;
    end
    n_checks++;
    if (!found) begin
      $display("FAIL result_seen: got no result_valid, required a pulse by cycle %0d", last_cyc + 2);
      return;
    end
    n_pass++;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: got an unexpected result at cycle %0d, required none", cyc);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (cyc !== last_cyc + 2) $display("FAIL %s latency: got cycle %0d required %0d", e.name, cyc, last_cyc + 2);
    else n_pass++;
    if (e.chk_seq) begin
      n_checks++;
      if (bus.seq_num_o !== e.seq) $display("FAIL %s seq_num: got %0h required %0h", e.name, bus.seq_num_o, e.seq);
      else n_pass++;
    end
    n_checks++;
    if ({bus.seq_ok_o, bus.seq_gap_o, bus.seq_low_o, bus.format_err_o} !== {e.ok, e.gap, e.low, e.err})
      $display("FAIL %s flags(ok,gap,low,err): got %b required %b", e.name,
               {bus.seq_ok_o, bus.seq_gap_o, bus.seq_low_o, bus.format_err_o}, {e.ok, e.gap, e.low, e.err});
    else n_pass++;
    n_checks++;
    if (bus.upd_valid_o !== e.ok) $display("FAIL %s upd_valid: got %b required %b", e.name, bus.upd_valid_o, e.ok);
    else n_pass++;
    if (e.ok) begin
      n_checks++;
      if (bus.upd_seq_num_o !== e.upd_seq) $display("FAIL %s upd_seq_num: got %0h required %0h", e.name, bus.upd_seq_num_o, e.upd_seq);
      else n_pass++;
      n_checks++;
      if (bus.upd_host_addr_o !== e.host) $display("FAIL %s upd_host_addr: got %0h required %0h", e.name, bus.upd_host_addr_o, e.host);
      else n_pass++;
    end
    $display("result %s: seq=%0d ok=%b gap=%b low=%b err=%b upd=%b", e.name, bus.seq_num_o,
             bus.seq_ok_o, bus.seq_gap_o, bus.seq_low_o, bus.format_err_o, bus.upd_valid_o);
  endtask

  // Pulses must drop the cycle after REPORT while flags stay held.
  task automatic pulse_drop(input logic [31:0] seq_hold);
    @(negedge clk);
    n_checks++;
    if ({bus.result_valid_o, bus.upd_valid_o} !== 2'b00)
      $display("FAIL pulse_drop: got result_valid,upd_valid=%b required 00", {bus.result_valid_o, bus.upd_valid_o});
    else n_pass++;
    n_checks++;
    if (bus.seq_num_o !== seq_hold) $display("FAIL seq_hold: got %0h required %0h", bus.seq_num_o, seq_hold);
    else n_pass++;
  endtask

  task automatic run_field(input string name, input logic [7:0] host, input logic [31:0] expv,
                           input string s, input logic [31:0] seq, input bit chk_seq,
                           input logic ok, input logic gap, input logic low, input logic err,
                           input logic [31:0] upd_seq);
    int lc;
    start_field(host, expv);
    push_exp(name, seq, chk_seq, ok, gap, low, err, host, upd_seq);
    send_chars(s, 1'b1, lc);
    await_result(lc);
    pulse_drop(bus.seq_num_o);
    tick();
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({bus.busy_o, bus.result_valid_o, bus.seq_ok_o, bus.seq_gap_o, bus.seq_low_o,
         bus.format_err_o, bus.upd_valid_o} !== 7'b0)
      $display("FAIL %s flags: got %b required 0000000", name, {bus.busy_o, bus.result_valid_o,
               bus.seq_ok_o, bus.seq_gap_o, bus.seq_low_o, bus.format_err_o, bus.upd_valid_o});
    else n_pass++;
    n_checks++;
    if ({bus.seq_num_o, bus.upd_seq_num_o, bus.upd_host_addr_o} !== 72'b0)
      $display("FAIL %s values: got seq=%0h upd_seq=%0h upd_host=%0h required 0", name,
               bus.seq_num_o, bus.upd_seq_num_o, bus.upd_host_addr_o);
    else n_pass++;
  endtask

  task automatic no_pulse_window(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.result_valid_o === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL %s: got %0d result pulses required 0", name, seen);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_in_order();
    run_field("in_order_42", 8'h5A, 32'd42, "42", 32'd42, 1, 1, 0, 0, 0, 32'd43);
  endtask

  task automatic test_gap_low();
    run_field("gap_9", 8'h11, 32'd7, "9", 32'd9, 1, 0, 1, 0, 0, 32'd0);
    run_field("low_5", 8'h12, 32'd7, "5", 32'd5, 1, 0, 0, 1, 0, 32'd0);
  endtask

  task automatic test_malformed();
    // Expected values are chosen so that an unflagged value would look in-order.
    run_field("err_1A3",      8'h21, 32'd13,         "1A3",         32'd0,  0, 0, 0, 0, 1, 32'd0);
    run_field("err_zero",     8'h22, 32'd0,          "0",           32'd0,  1, 0, 0, 0, 1, 32'd0);
    run_field("err_11digits", 8'h23, 32'd1,          "00000000001", 32'd0,  0, 0, 0, 0, 1, 32'd0);
    run_field("err_overflow", 8'h24, 32'hFFFF_FFFF,  "4294967296",  32'd0,  0, 0, 0, 0, 1, 32'd0);
  endtask

  task automatic test_wrap();
    run_field("wrap_max", 8'h33, 32'hFFFF_FFFF, "4294967295", 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 32'd0);
  endtask

  task automatic test_reset_mid();
    int lc;
    start_field(8'h44, 32'd123);
    send_chars("12", 1'b0, lc);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    no_pulse_window("reset_mid_no_result", 6);
    tick();
    run_field("after_reset_5", 8'h45, 32'd5, "5", 32'd5, 1, 1, 0, 0, 0, 32'd6);
  endtask

  task automatic test_restart();
    int lc;
    start_field(8'h50, 32'd12);
    send_chars("12", 1'b0, lc);
    start_field(8'h51, 32'd77);
    push_exp("restart_77", 32'd77, 1, 1, 0, 0, 0, 8'h51, 32'd78);
    send_chars("77", 1'b1, lc);
    await_result(lc);
    pulse_drop(32'd77);
    no_pulse_window("restart_single_result", 5);
    tick();
  endtask

  task automatic test_back_to_back();
    int lca, lcb;
    start_field(8'h61, 32'd3);
    push_exp("b2b_A", 32'd3, 1, 1, 0, 0, 0, 8'h61, 32'd4);
    send_chars("3", 1'b1, lca);
    tick();  // REPORT of field A begins at the next edge
    bus.start_i        = 1'b1;
    bus.host_addr_i    = 8'h62;
    bus.expected_seq_i = 32'd4;
    await_result(lca);
    tick();
    bus.start_i = 1'b0;
    push_exp("b2b_B", 32'd4, 1, 1, 0, 0, 0, 8'h62, 32'd5);
    send_chars("4", 1'b1, lcb);
    await_result(lcb);
    pulse_drop(32'd4);
    tick();
  endtask

  initial begin
    bus.start_i        = 1'b0;
    bus.host_addr_i    = '0;
    bus.expected_seq_i = '0;
    bus.char_valid_i   = 1'b0;
    bus.char_i         = '0;
    bus.char_last_i    = 1'b0;

    test_reset();
    test_in_order();
    test_gap_low();
    test_malformed();
    test_wrap();
    test_reset_mid();
    test_restart();
    test_back_to_back();

    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by %0t required finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_num_checker.md
Name: seq_num_checker

Overview:
- Receive-side counterpart of the outgoing sequence-number generator.
- Consumes the ASCII digits of an incoming MsgSeqNum (tag 34) value byte-serially and converts them to 32-bit binary.
- Compares the result against the expected sequence number for the sending host and classifies it as in-order, gap (too high), low (duplicate/stale) or malformed.
- Emits a counter-update request so the session manager can advance the per-host expected counter.

Parameters:
- HOST_ADDR, `HOST_ADDR_WIDTH: width of host address.
- BIN_W, 32: binary sequence-number width.
- MAX_DIGITS, 10: maximum accepted ASCII digits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- start_i  in  1  begin new field; latches host_addr_i and expected_seq_i.
- host_addr_i  in  HOST_ADDR  host the message was received from.
- expected_seq_i  in  BIN_W  expected sequence number for that host, binary.
- char_valid_i  in  1  char_i is valid this cycle.
- char_i  in  8  ASCII character of the tag-34 value.
- char_last_i  in  1  qualifies the final character of the value.
- busy_o  out  1  high while not IDLE.
- result_valid_o  out  1  one-cycle pulse; the result outputs below are valid.
- seq_num_o  out  BIN_W  decoded value; held until the next start_i.
- seq_ok_o  out  1  received value == expected.
- seq_gap_o  out  1  received value > expected.
- seq_low_o  out  1  received value < expected.
- format_err_o  out  1  malformed value.
- upd_valid_o  out  1  one-cycle pulse requesting a counter update.
- upd_host_addr_o  out  HOST_ADDR  host whose counter is updated.
- upd_seq_num_o  out  BIN_W  new expected value.

Behaviour:
- Reset: rst low at a clock edge → state IDLE, accumulator and digit count cleared, all outputs 0. Reset mid-field discards the field; no result is produced.
- FSM has four states: IDLE, ACCUM, CHECK, REPORT.
- IDLE:
  - char_valid_i is ignored.
  - start_i → ACCUM; accumulator := 0, digit count := 0, err := 0, host and expected are latched.
- ACCUM, on each char_valid_i:
  - Digit ('0'..'9', 0x30..0x39): acc := acc*10 + (char - 0x30). Compute in BIN_W+4 bits using shift-add (acc<<3 + acc<<1).
  - Non-digit character: sticky err := 1; keep consuming.
  - Digit count reaching MAX_DIGITS+1: err := 1.
  - Intermediate result exceeding 2^BIN_W-1: err := 1; acc saturates so it cannot wrap.
  - char_valid_i && char_last_i → CHECK (last char processed first).
  - start_i in ACCUM: abort current field, restart with freshly latched inputs; no result for the aborted field.
- CHECK, one cycle:
  - Final value 0 sets err (FIX sequence numbers start at 1).
  - Compare against latched expected.
  - Inputs are ignored.
- REPORT, one cycle, then → IDLE:
  - result_valid_o = 1. Exactly one of seq_ok_o / seq_gap_o / seq_low_o / format_err_o is 1.
  - format_err_o has priority; the other three are 0 when it is set.
  - seq_ok_o → upd_valid_o = 1, upd_host_addr_o = latched host, upd_seq_num_o = seq+1, modulo 2^BIN_W (0xFFFFFFFF → 0).
  - Gap, low or err → no update pulse.
  - start_i in REPORT is honoured: → ACCUM next cycle.
- Latency: last char accepted at cycle N → result_valid_o at N+2. Back-to-back fields are possible with start_i in REPORT.
- Flag and seq outputs hold until the next start_i. The two pulse outputs are single-cycle.
- Leading zeros are accepted and count toward MAX_DIGITS.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/ACCUM/CHECK/REPORT).
  - ASCII_0 = 8'h30 and ASCII_9 = 8'h39.
  - BIN_W and MAX_DIGITS defaults.
  - Result-status encoding.
- Sub-module ascii_to_binary: digit accumulator with overflow, non-digit and digit-count detection. It is the inverse of the existing binary_to_bcd/ASCII path. The checker FSM instantiates it.

Test Plan:
- Expected 42, field "42" last on '2' → result_valid at N+2, seq_num_o=42, seq_ok_o=1, upd_valid_o=1, upd_seq_num_o=43, upd_host_addr_o=latched host.
- Expected 7, field "9" → seq_gap_o=1, seq_num_o=9, no upd pulse. Expected 7, field "5" → seq_low_o=1.
- Malformed fields, each → format_err_o=1 only, no upd:
  - "1A3";
  - "0";
  - "00000000001" (11 digits);
  - "4294967296" (overflow).
- Expected 0xFFFFFFFF, field "4294967295" → seq_ok_o=1, upd_seq_num_o=0.
- Reset or restart mid-field:
  - rst low after "12" of "123" → no result_valid, all outputs 0. Then a fresh "5" with expected 5 → ok.
  - start_i mid-field → aborted field produces no result.
- Back-to-back: start_i asserted in the REPORT cycle of field A ("3", expected 3), then field B ("4", expected 4) → two result pulses, B's exactly 2 cycles after its last char, both ok.
